// File: rtl/msg_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between three message requesters.
// The granted message is snapshotted and streamed MSB byte first through a start/done handshake.
module msg_tx_arbiter #(
   parameter int MSG_BYTES  = 12,
   parameter int GAP_CYCLES = 4340
) (
   input  logic                     clk_50M,
   input  logic                     rst_n,
   input  logic [2:0]               req,
   input  logic [3*8*MSG_BYTES-1:0] msg_in,
   input  logic [11:0]              msg_len,
   output logic [2:0]               ack,
   output logic                     busy,
   output logic [1:0]               grant_id,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_done
);

   localparam int MW = 8*MSG_BYTES;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, ACK, GAP} state_t;

   state_t        state, state_nxt;
   logic [1:0]    last;
   logic [MW-1:0] msg_buf;
   logic [3:0]    len, idx;
   logic [GW-1:0] gap_cnt;

   logic [1:0]    p0, p1, gnt;
   logic          gnt_vld;
   logic [3:0]    len_raw, len_clamp;

   // Search order last+1, last+2, last: the previous winner always ranks lowest.
   always_comb begin
      p0      = (last == 2'd2) ? 2'd0 : last + 2'd1;
      p1      = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
      gnt_vld = |req;
      if (req[p0])      gnt = p0;
      else if (req[p1]) gnt = p1;
      else              gnt = last;
      len_raw   = msg_len[4*gnt +: 4];
      len_clamp = (len_raw > 4'(MSG_BYTES)) ? 4'(MSG_BYTES) : len_raw;
   end

   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      ack       = 3'b000;
      case (state)
         IDLE:      if (gnt_vld) state_nxt = (len_clamp == 4'd0) ? ACK : SEND;
         SEND: begin
            tx_start  = 1'b1;
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: if (tx_done) state_nxt = (idx == len - 4'd1) ? ACK : SEND;
         ACK: begin
            ack       = 3'b001 << grant_id;
            state_nxt = GAP;
         end
         GAP:       if (gap_cnt == '0) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign tx_data = msg_buf[MW-1 -: 8];

   // The buffer shifts left after each accepted byte so the current byte is always on top.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 2'd2;
         grant_id <= 2'd0;
         msg_buf  <= '0;
         len      <= 4'd0;
         idx      <= 4'd0;
         gap_cnt  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (gnt_vld) begin
               grant_id <= gnt;
               last     <= gnt;
               len      <= len_clamp;
               idx      <= 4'd0;
               if (len_clamp != 4'd0) msg_buf <= msg_in[MW*gnt +: MW];
            end
            WAIT_DONE: if (tx_done && (idx != len - 4'd1)) begin
               idx     <= idx + 4'd1;
               msg_buf <= {msg_buf[MW-9:0], 8'h00};
            end
            ACK:     gap_cnt <= GW'(GAP_CYCLES - 1);
            GAP:     if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Scoreboard bench for msg_tx_arbiter: a queue-based reference model predicts every
// tx_start byte and ack pulse with its cycle; a monitor pops and compares.
module tb_msg_tx_arbiter;

   localparam int MB  = 12;
   localparam int GAP = 16;
   localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_ACK = 3, P_GAP = 4;

   logic            clk_50M = 1'b0;
   logic            rst_n;
   logic [2:0]      req;
   logic [3*8*MB-1:0] msg_in;
   logic [11:0]     msg_len;
   logic [2:0]      ack;
   logic            busy;
   logic [1:0]      grant_id;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            tx_done;
   logic            uart_done = 1'b0, spur_done;
   int              u_dly, u_cnt = 0;

   msg_tx_arbiter #(.MSG_BYTES(MB), .GAP_CYCLES(GAP)) dut (
      .clk_50M(clk_50M), .rst_n(rst_n), .req(req), .msg_in(msg_in), .msg_len(msg_len),
      .ack(ack), .busy(busy), .grant_id(grant_id), .tx_data(tx_data),
      .tx_start(tx_start), .tx_done(tx_done)
   );

   always #10 clk_50M = ~clk_50M;
   assign tx_done = uart_done | spur_done;

   // UART stand-in: one-cycle done pulse u_dly cycles after each start.
   always @(negedge clk_50M) begin
      uart_done = 1'b0;
      if (u_cnt > 0) begin
         u_cnt--;
         if (u_cnt == 0) uart_done = 1'b1;
      end
      if (tx_start) u_cnt = u_dly;
   end

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {int cyc; bit is_ack; int id; logic [7:0] val;} ev_t;
   ev_t        exp_q[$];
   logic [7:0] m_q[$];
   int cyc = 0, ph = P_IDLE, gap_left = 0, m_last = 2, mg = 0, ml = 0;

   function automatic void push_ev(input bit a, input int id, input logic [7:0] v);
      ev_t e;
      e.cyc = cyc; e.is_ack = a; e.id = id; e.val = v;
      exp_q.push_back(e);
   endfunction

   always @(posedge clk_50M) begin
      cyc++;
      if (!rst_n) begin
         ph = P_IDLE; m_last = 2; mg = 0; m_q.delete();
      end else begin
         case (ph)
            P_IDLE: if (req != 3'b000) begin
               mg = -1;
               for (int k = 1; k <= 3; k++)
                  if (mg < 0 && req[(m_last + k) % 3]) mg = (m_last + k) % 3;
               m_last = mg;
               ml = int'(msg_len[4*mg +: 4]);
               if (ml > MB) ml = MB;
               for (int b = 0; b < ml; b++) m_q.push_back(msg_in[mg*8*MB + (MB-1-b)*8 +: 8]);
               if (ml == 0) begin ph = P_ACK; push_ev(1'b1, mg, 8'h00); end
               else begin ph = P_START; push_ev(1'b0, mg, m_q[0]); end
            end
            P_START: ph = P_WAIT;
            P_WAIT: if (tx_done) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) begin ph = P_ACK; push_ev(1'b1, mg, 8'h00); end
               else begin ph = P_START; push_ev(1'b0, mg, m_q[0]); end
            end
            P_ACK: begin ph = P_GAP; gap_left = GAP; end
            P_GAP: if (gap_left == 1) ph = P_IDLE; else gap_left--;
            default: ph = P_IDLE;
         endcase
      end
   end

   // ---------------- monitor ----------------
   logic [7:0] tx_log[$];
   int         ack_log[$];
   ev_t        e;

   always @(posedge clk_50M) begin
      #1;
      if (tx_start) begin
         tx_log.push_back(tx_data);
         if (exp_q.size() == 0 || exp_q[0].is_ack) chk("unexpected_tx_start", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("tx_cycle", cyc, e.cyc);
            chk("tx_data", int'(tx_data), int'(e.val));
            chk("tx_grant_id", int'(grant_id), e.id);
         end
      end
      if (ack != 3'b000) begin
         ack_log.push_back((ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : 3);
         if (exp_q.size() == 0 || !exp_q[0].is_ack) chk("unexpected_ack", int'(ack), 0);
         else begin
            e = exp_q.pop_front();
            chk("ack_cycle", cyc, e.cyc);
            chk("ack_vec", int'(ack), 1 << e.id);
         end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         chk("missed_event_cycle", cyc, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      chk("busy", int'(busy), int'(ph != P_IDLE));
      if (busy) chk("grant_id", int'(grant_id), mg);
   end

   // ---------------- stimulus ----------------
   task automatic rand_msgs();
      for (int w = 0; w < 9; w++) msg_in[w*32 +: 32] = $urandom();
      msg_len = 12'($urandom());
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while (busy && t < budget) begin @(negedge clk_50M); t++; end
      if (t >= budget) chk("wait_idle_timeout", t, 0);
   endtask

   task automatic wait_tx(input int n, input int budget);
      int t = 0;
      while (tx_log.size() < n && t < budget) begin @(negedge clk_50M); t++; end
      if (t >= budget) chk("wait_tx_timeout", tx_log.size(), n);
   endtask

   task automatic wait_ack(input int n, input int budget);
      int t = 0;
      while (ack_log.size() < n && t < budget) begin @(negedge clk_50M); t++; end
      if (t >= budget) chk("wait_ack_timeout", ack_log.size(), n);
   endtask

   // Raise mask; each requester drops its req when acked. Optional input scrambling
   // while busy and spurious tx_done pulses once all are acked (i.e. during GAP).
   task automatic run(input logic [2:0] mask, input bit scr, input bit spur, input int budget);
      int t = 0;
      req = mask;
      while ((req != 3'b000 || busy) && t < budget) begin
         @(negedge clk_50M); t++;
         spur_done = 1'b0;
         req = req & ~ack;
         if (scr && busy) rand_msgs();
         if (spur && req == 3'b000 && busy) spur_done = 1'($urandom_range(0, 1));
      end
      spur_done = 1'b0;
      if (t >= budget) chk("run_timeout", t, 0);
   endtask

   int         rr_exp[4] = '{0, 1, 2, 0};
   logic [7:0] snap[MB];
   int         n0;

   initial begin
      rst_n = 1'b0; req = 3'b111; spur_done = 1'b0; u_dly = 10;
      rand_msgs();
      msg_len = 12'h111;
      repeat (4) @(negedge clk_50M);
      chk("rst_ack", int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_tx_start", int'(tx_start), 0);

      // round-robin with all three requesting continuously
      tx_log.delete(); ack_log.delete();
      msg_len = 12'h222;
      rst_n = 1'b1;
      wait_ack(4, 3000);
      req = 3'b000;
      wait_idle(200);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), (i < ack_log.size()) ? ack_log[i] : -1, rr_exp[i]);

      // single 3-byte message from requester 1
      tx_log.delete(); ack_log.delete();
      msg_in = '0;
      msg_in[8*MB + 88 +: 8] = 8'h50;
      msg_in[8*MB + 80 +: 8] = 8'h42;
      msg_in[8*MB + 72 +: 8] = 8'h4D;
      msg_len = 12'h030;
      run(3'b010, 1'b0, 1'b0, 2000);
      chk("pbm_count", tx_log.size(), 3);
      if (tx_log.size() == 3) begin
         chk("pbm_b0", int'(tx_log[0]), 8'h50);
         chk("pbm_b1", int'(tx_log[1]), 8'h42);
         chk("pbm_b2", int'(tx_log[2]), 8'h4D);
      end

      // len 0: ack with no bytes
      tx_log.delete(); ack_log.delete();
      msg_len = 12'h000;
      run(3'b100, 1'b0, 1'b0, 500);
      chk("len0_tx_count", tx_log.size(), 0);
      chk("len0_ack_id", (ack_log.size() == 1) ? ack_log[0] : -1, 2);

      // len 15 clamps to 12; inputs scrambled after grant
      tx_log.delete(); ack_log.delete();
      rand_msgs();
      msg_len = 12'h00F;
      for (int b = 0; b < MB; b++) snap[b] = msg_in[(MB-1-b)*8 +: 8];
      u_dly = 3;
      run(3'b001, 1'b1, 1'b0, 2000);
      chk("len15_tx_count", tx_log.size(), MB);
      for (int b = 0; b < MB && b < tx_log.size(); b++)
         chk($sformatf("snapshot_b%0d", b), int'(tx_log[b]), int'(snap[b]));

      // spurious tx_done in IDLE, then in GAP
      @(negedge clk_50M); spur_done = 1'b1;
      @(negedge clk_50M); spur_done = 1'b0;
      @(negedge clk_50M);
      chk("spur_idle_busy", int'(busy), 0);
      tx_log.delete(); ack_log.delete();
      msg_len = 12'h200;
      run(3'b001, 1'b0, 1'b1, 2000);
      chk("spur_gap_ack", ack_log.size(), 1);

      // req[2] dropped after first byte of four
      tx_log.delete(); ack_log.delete();
      rand_msgs();
      msg_len = 12'h400;
      u_dly = 6;
      req = 3'b100;
      wait_tx(1, 200);
      req = 3'b000;
      wait_ack(1, 500);
      wait_idle(200);
      chk("drop_tx_count", tx_log.size(), 4);
      chk("drop_ack_id", (ack_log.size() > 0) ? ack_log[0] : -1, 2);

      // reset during WAIT_DONE of byte 2
      tx_log.delete(); ack_log.delete();
      rand_msgs();
      msg_len = 12'h006;
      u_dly = 10;
      req = 3'b001;
      wait_tx(2, 200);
      @(negedge clk_50M);
      rst_n = 1'b0;
      repeat (2) @(negedge clk_50M);
      chk("midrst_busy", int'(busy), 0);
      rst_n = 1'b1;
      n0 = tx_log.size();
      wait_ack(1, 1000);
      req = 3'b000;
      wait_idle(200);
      chk("midrst_no_extra_ack", ack_log.size(), 1);
      chk("midrst_restart_byte0", (tx_log.size() > n0) ? int'(tx_log[n0]) : -1, int'(msg_in[(MB-1)*8 +: 8]));
      chk("midrst_tx_count", tx_log.size(), n0 + 6);

      // randomized traffic
      for (int it = 0; it < 12; it++) begin
         rand_msgs();
         u_dly = $urandom_range(1, 12);
         run(3'($urandom_range(1, 7)), 1'b1, 1'b1, 4000);
      end

      repeat (3) @(negedge clk_50M);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL global_timeout: got %0d checks, expected completion", n_chk);
      $fatal(1);
   end

endmodule
